// File: rtl/gen_cell.sv
// One cell of a generations-style cellular automaton: counts live neighbours
// and applies a birth/survive/decay rule each time a step is requested.
module gen_cell #(
  parameter int unsigned NEIGHBORS = 8,
  parameter int unsigned STATE_W   = 2,
  parameter int unsigned SERIAL    = 0,
  parameter int unsigned GEN_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NEIGHBORS-1:0] adjSignals,
  input  logic                 step,
  input  logic                 load,
  input  logic [STATE_W-1:0]   loadVal,
  input  logic [NEIGHBORS:0]   birthMask,
  input  logic [NEIGHBORS:0]   surviveMask,
  input  logic [STATE_W-1:0]   maxState,
  output logic [STATE_W-1:0]   out,
  output logic                 alive,
  output logic                 busy,
  output logic                 done,
  output logic                 changed,
  output logic [GEN_W-1:0]     generation
);

  localparam int unsigned CNT_W = $clog2(NEIGHBORS + 1);
  localparam int unsigned IDX_W = (NEIGHBORS > 1) ? $clog2(NEIGHBORS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t               state;
  logic [NEIGHBORS-1:0] snap;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     pop_c;
  logic [STATE_W-1:0]   max_eff_c;
  logic [STATE_W-1:0]   next_c;

  function automatic logic [CNT_W-1:0] popcount(input logic [NEIGHBORS-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(NEIGHBORS); i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction

  always_comb begin
    pop_c = popcount(snap);
  end

  // Rule evaluation; masks and maxState are live inputs, used only in APPLY.
  always_comb begin
    max_eff_c = (maxState == '0) ? STATE_W'(1) : maxState;
    next_c    = '0;
    if (out > max_eff_c) begin
      next_c = '0;
    end else if (out == '0) begin
      next_c = birthMask[cnt] ? STATE_W'(1) : '0;
    end else if (out == STATE_W'(1)) begin
      if (surviveMask[cnt]) begin
        next_c = STATE_W'(1);
      end else if (max_eff_c == STATE_W'(1)) begin
        next_c = '0;
      end else begin
        next_c = STATE_W'(2);
      end
    end else if (out == max_eff_c) begin
      next_c = '0;
    end else begin
      next_c = out + STATE_W'(1);
    end
  end

  // Control FSM with registered outputs; load overrides everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      snap       <= '0;
      cnt        <= '0;
      idx        <= '0;
      out        <= '0;
      alive      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      changed    <= 1'b0;
      generation <= '0;
    end else begin
      done    <= 1'b0;
      changed <= 1'b0;
      if (load) begin
        state      <= IDLE;
        busy       <= 1'b0;
        out        <= loadVal;
        alive      <= (loadVal == STATE_W'(1));
        generation <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (step) begin
              snap  <= adjSignals;
              cnt   <= '0;
              idx   <= '0;
              state <= COUNT;
              busy  <= 1'b1;
            end
          end
          COUNT: begin
            if (SERIAL != 0) begin
              cnt <= cnt + CNT_W'(snap[idx]);
              idx <= idx + IDX_W'(1);
              if (idx == IDX_W'(NEIGHBORS - 1)) begin
                state <= APPLY;
              end
            end else begin
              cnt   <= pop_c;
              state <= APPLY;
            end
          end
          APPLY: begin
            out        <= next_c;
            alive      <= (next_c == STATE_W'(1));
            done       <= 1'b1;
            changed    <= (next_c != out);
            generation <= generation + GEN_W'(1);
            state      <= IDLE;
            busy       <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gen_cell.sv
// Bench for gen_cell: a parallel-count instance and a serial-count instance
// with a 2-bit generation counter, checked against a rule-level model.
module tb_gen_cell;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] adj = '0;
  logic       step_p = 1'b0, step_s = 1'b0;
  logic       load_p = 1'b0, load_s = 1'b0;
  logic [1:0] loadv = '0;
  logic [8:0] bm = 9'h008, sm = 9'h00C;
  logic [1:0] ms = 2'd1;

  logic [1:0] out_p, out_s;
  logic       alive_p, busy_p, done_p, changed_p;
  logic       alive_s, busy_s, done_s, changed_s;
  logic [7:0] gen_p;
  logic [1:0] gen_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gen_cell #(.NEIGHBORS(8), .STATE_W(2), .SERIAL(0), .GEN_W(8)) u_par (
    .clock(clk), .reset(rst_n), .adjSignals(adj), .step(step_p), .load(load_p),
    .loadVal(loadv), .birthMask(bm), .surviveMask(sm), .maxState(ms),
    .out(out_p), .alive(alive_p), .busy(busy_p), .done(done_p),
    .changed(changed_p), .generation(gen_p)
  );

  gen_cell #(.NEIGHBORS(8), .STATE_W(2), .SERIAL(1), .GEN_W(2)) u_ser (
    .clock(clk), .reset(rst_n), .adjSignals(adj), .step(step_s), .load(load_s),
    .loadVal(loadv), .birthMask(bm), .surviveMask(sm), .maxState(ms),
    .out(out_s), .alive(alive_s), .busy(busy_s), .done(done_s),
    .changed(changed_s), .generation(gen_s)
  );

  // Rule model straight from the generations automaton definition.
  function automatic int mdl_next(int s, int n, int bmask, int smask, int mx);
    int m;
    m = (mx == 0) ? 1 : mx;
    if (s == 0) return (bmask >> n) & 1;
    if (s == 1) return ((smask >> n) & 1) ? 1 : ((m == 1) ? 0 : 2);
    if (s >= m) return 0;
    return s + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_par(input int v);
    loadv = 2'(v); load_p = 1'b1; tick(); load_p = 1'b0;
  endtask

  task automatic load_ser(input int v);
    loadv = 2'(v); load_s = 1'b1; tick(); load_s = 1'b0;
  endtask

  task automatic step_par(output int lat);
    step_p = 1'b1; tick(); step_p = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done_p === 1'b1) begin lat = c; break; end
    end
  endtask

  task automatic step_ser(output int lat);
    step_s = 1'b1; tick(); step_s = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done_s === 1'b1) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_vec++; if (out_p !== 2'd0) begin n_err++; $display("FAIL reset_out_p: got %0d expected 0", out_p); end
    n_vec++; if (gen_p !== 8'd0) begin n_err++; $display("FAIL reset_gen_p: got %0d expected 0", gen_p); end
    n_vec++; if ({busy_p, done_p, changed_p, alive_p} !== 4'b0) begin n_err++; $display("FAIL reset_flags_p: got %b expected 0000", {busy_p, done_p, changed_p, alive_p}); end
    n_vec++; if ({out_s, gen_s, busy_s, done_s} !== 6'b0) begin n_err++; $display("FAIL reset_ser: got %b expected 000000", {out_s, gen_s, busy_s, done_s}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_b3s23();
    bm = 9'h008; sm = 9'h00C; ms = 2'd1;
    load_par(0);
    adj = 8'b0000_0111;
    step_p = 1'b1; tick(); step_p = 1'b0;
    tick();
    n_vec++; if ({busy_p, done_p} !== 2'b10) begin n_err++; $display("FAIL b3s23_mid: got busy/done %b expected 10", {busy_p, done_p}); end
    tick();
    n_vec++; if (done_p !== 1'b1) begin n_err++; $display("FAIL b3s23_done: got %b expected 1", done_p); end
    n_vec++; if (out_p !== 2'd1) begin n_err++; $display("FAIL b3s23_out: got %0d expected 1", out_p); end
    n_vec++; if ({changed_p, alive_p} !== 2'b11) begin n_err++; $display("FAIL b3s23_chg_alive: got %b expected 11", {changed_p, alive_p}); end
    n_vec++; if (gen_p !== 8'd1) begin n_err++; $display("FAIL b3s23_gen: got %0d expected 1", gen_p); end
    tick();
    n_vec++; if ({busy_p, done_p} !== 2'b00) begin n_err++; $display("FAIL b3s23_after: got busy/done %b expected 00", {busy_p, done_p}); end
  endtask

  task automatic test_serial();
    int bc, lat;
    bm = 9'h008; sm = 9'h00C; ms = 2'd1;
    load_ser(1);
    adj = 8'h01;
    step_s = 1'b1; tick(); step_s = 1'b0;
    bc = 0; lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (busy_s === 1'b1) bc++;
      tick();
      if (done_s === 1'b1) begin lat = c; break; end
    end
    n_vec++; if (lat != 9) begin n_err++; $display("FAIL serial_latency: got %0d expected 9", lat); end
    n_vec++; if (bc != 9) begin n_err++; $display("FAIL serial_busy_cycles: got %0d expected 9", bc); end
    n_vec++; if (out_s !== 2'd0 || changed_s !== 1'b1) begin n_err++; $display("FAIL serial_out: got %0d/%b expected 0/1", out_s, changed_s); end
  endtask

  task automatic test_multistate();
    int lat;
    int exp_seq[3] = '{2, 3, 0};
    ms = 2'd3; sm = 9'h000; bm = 9'h000;
    load_par(1);
    n_vec++; if (alive_p !== 1'b1) begin n_err++; $display("FAIL multi_alive0: got %b expected 1", alive_p); end
    for (int i = 0; i < 3; i++) begin
      step_par(lat);
      n_vec++; if (out_p !== 2'(exp_seq[i]) || lat != 2) begin n_err++; $display("FAIL multi_step%0d: got out %0d lat %0d expected out %0d lat 2", i, out_p, lat, exp_seq[i]); end
      n_vec++; if (alive_p !== 1'b0) begin n_err++; $display("FAIL multi_alive%0d: got %b expected 0", i + 1, alive_p); end
    end
    n_vec++; if (gen_p !== 8'd3) begin n_err++; $display("FAIL multi_gen: got %0d expected 3", gen_p); end
  endtask

  task automatic test_abort();
    bit saw;
    bm = 9'h008; sm = 9'h00C; ms = 2'd1;
    load_par(0);
    adj = 8'h07;
    step_p = 1'b1; tick();
    tick();
    step_p = 1'b0;
    load_p = 1'b1; loadv = 2'd2; tick(); load_p = 1'b0;
    n_vec++; if (done_p !== 1'b0 || out_p !== 2'd2) begin n_err++; $display("FAIL abort_out: got done %b out %0d expected 0/2", done_p, out_p); end
    n_vec++; if (gen_p !== 8'd0 || busy_p !== 1'b0) begin n_err++; $display("FAIL abort_gen_busy: got %0d/%b expected 0/0", gen_p, busy_p); end
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done_p !== 1'b0 || busy_p !== 1'b0) saw = 1'b1;
    end
    n_vec++; if (saw) begin n_err++; $display("FAIL abort_quiet: got activity 1 expected 0"); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit saw;
    bm = 9'h008; sm = 9'h00C; ms = 2'd1;
    load_ser(1);
    adj = 8'h06;
    step_s = 1'b1; tick(); step_s = 1'b0;
    tick(); tick();
    step_s = 1'b1; tick(); step_s = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done_s === 1'b1) begin lat = c; break; end
    end
    n_vec++; if (lat != 6) begin n_err++; $display("FAIL b2b_first_done: got %0d expected 6", lat); end
    n_vec++; if (out_s !== 2'd1 || gen_s !== 2'd1 || changed_s !== 1'b0) begin n_err++; $display("FAIL b2b_result: got out %0d gen %0d chg %b expected 1/1/0", out_s, gen_s, changed_s); end
    saw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (busy_s !== 1'b0 || done_s !== 1'b0) saw = 1'b1;
    end
    n_vec++; if (saw) begin n_err++; $display("FAIL b2b_no_queue: got activity 1 expected 0"); end
    step_ser(lat);
    n_vec++; if (lat != 9 || gen_s !== 2'd2) begin n_err++; $display("FAIL b2b_next: got lat %0d gen %0d expected 9/2", lat, gen_s); end
  endtask

  task automatic test_gen_wrap();
    int lat, s, e;
    bm = 9'h008; sm = 9'h00C; ms = 2'd1;
    load_ser(0);
    s = 0;
    for (int i = 0; i < 5; i++) begin
      adj = 8'($urandom);
      e = mdl_next(s, $countones(adj), 32'h008, 32'h00C, 1);
      step_ser(lat);
      n_vec++; if (out_s !== 2'(e) || gen_s !== 2'((i + 1) % 4) || lat != 9) begin n_err++; $display("FAIL wrap_step%0d: got out %0d gen %0d lat %0d expected %0d/%0d/9", i, out_s, gen_s, lat, e, (i + 1) % 4); end
      s = e;
    end
    n_vec++; if (gen_s !== 2'd1) begin n_err++; $display("FAIL wrap_final: got %0d expected 1", gen_s); end
    ms = 2'd2;
    load_ser(3);
    step_ser(lat);
    n_vec++; if (out_s !== 2'd0 || lat != 9) begin n_err++; $display("FAIL over_max: got out %0d lat %0d expected 0/9", out_s, lat); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit saw;
    bm = 9'h008; sm = 9'h00C; ms = 2'd1;
    load_par(1);
    adj = 8'h00;
    step_p = 1'b1; tick(); step_p = 1'b0;
    n_vec++; if (busy_p !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b expected 1", busy_p); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_p !== 2'd0 || busy_p !== 1'b0 || gen_p !== 8'd0) begin n_err++; $display("FAIL rmid_async: got out %0d busy %b gen %0d expected 0/0/0", out_p, busy_p, gen_p); end
    saw = 1'b0;
    tick();
    if (done_p !== 1'b0) saw = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done_p !== 1'b0 || busy_p !== 1'b0) saw = 1'b1;
    end
    n_vec++; if (saw) begin n_err++; $display("FAIL rmid_no_done: got activity 1 expected 0"); end
    adj = 8'h07;
    step_par(lat);
    n_vec++; if (lat != 2 || out_p !== 2'd1 || gen_p !== 8'd1) begin n_err++; $display("FAIL rmid_restart: got lat %0d out %0d gen %0d expected 2/1/1", lat, out_p, gen_p); end
  endtask

  task automatic test_random();
    int s, g, e, n, lat;
    load_par(0);
    s = 0; g = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(7) == 0) begin
        e = int'($urandom_range(3));
        load_par(e);
        s = e; g = 0;
        n_vec++; if (out_p !== 2'(s) || gen_p !== 8'd0) begin n_err++; $display("FAIL rnd_load%0d: got out %0d gen %0d expected %0d/0", i, out_p, gen_p, s); end
      end else begin
        adj = 8'($urandom);
        n = $countones(adj);
        step_p = 1'b1; tick(); step_p = 1'b0;
        adj = 8'($urandom);
        bm = 9'($urandom); sm = 9'($urandom); ms = 2'($urandom);
        e = mdl_next(s, n, int'(bm), int'(sm), int'(ms));
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
          tick();
          if (done_p === 1'b1) begin lat = c; break; end
        end
        g = (g + 1) % 256;
        n_vec++; if (lat != 2 || out_p !== 2'(e) || gen_p !== 8'(g)) begin n_err++; $display("FAIL rnd_step%0d: got lat %0d out %0d gen %0d expected 2/%0d/%0d", i, lat, out_p, gen_p, e, g); end
        n_vec++; if (changed_p !== 1'(e != s) || alive_p !== 1'(e == 1)) begin n_err++; $display("FAIL rnd_flags%0d: got chg %b alive %b expected %b/%b", i, changed_p, alive_p, e != s, e == 1); end
        s = e;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_b3s23();
    test_serial();
    test_multistate();
    test_abort();
    test_back_to_back();
    test_gen_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
